// File: rtl/param_update_sequencer_if.sv
// Host request, frame-status and register-bank write-port bundle for param_update_sequencer.
// "slave" is the sequencer's view; "master" is the host/frame side driving requests and status.
interface param_update_sequencer_if #(
  parameter int DEPTH = 8,
  parameter int AW    = 8,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          host_valid;
  logic          host_ready;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_data;
  logic          flush;
  logic          re_busy;
  logic          exp_active;
  logic          hold;
  logic          wr_en;
  logic [AW-1:0] varAddress;
  logic [DW-1:0] varValueIn;
  logic [CW-1:0] pending;
  logic          burst_done;
  logic          overflow;

  modport master (
    output host_valid, host_addr, host_data, flush, re_busy, exp_active, hold,
    input  host_ready, wr_en, varAddress, varValueIn, pending, burst_done, overflow
  );

  modport slave (
    input  host_valid, host_addr, host_data, flush, re_busy, exp_active, hold,
    output host_ready, wr_en, varAddress, varValueIn, pending, burst_done, overflow
  );
endinterface

// File: rtl/param_update_sequencer.sv
// Queues host timing-parameter writes and replays them to the register bank only
// in an inter-frame gap that has stayed open for GUARD consecutive cycles.
module param_update_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW    = 8,
  parameter int DW    = 32,
  parameter int GUARD = 16
) (
  input  logic                   CLK,
  input  logic                   rst,
  param_update_sequencer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_GUARD, ST_WRITE, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic [GW-1:0]    guard_q, guard_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic             overflow_q, overflow_d;
  logic             host_ready_q;
  logic             wr_en_q;
  logic             burst_done_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    data_q;
  logic [AW+DW-1:0] mem [DEPTH];

  logic gap, full, empty, push, pop;

  assign gap   = !bus.re_busy && !bus.exp_active && !bus.hold;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  // The last guard cycle already pops, so the first strobe lands exactly GUARD edges after the gap opens.
  assign pop   = !bus.flush && gap && !empty &&
                 ((state_q == ST_GUARD && guard_q == GUARD_LAST) || state_q == ST_WRITE);
  assign push  = bus.host_valid && !bus.flush && (!full || pop);

  always_comb begin
    count_d    = count_q + CW'(push) - CW'(pop);
    overflow_d = overflow_q | (bus.host_valid && full && !pop);
    if (bus.flush) begin
      count_d    = '0;
      overflow_d = 1'b0;
    end
  end

  // The IDLE cycle that sees the gap counts as the first idle cycle of the guard window.
  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    case (state_q)
      ST_IDLE: begin
        guard_d = '0;
        if (!empty && gap && !bus.flush) begin
          state_d = ST_GUARD;
          guard_d = GW'(1);
        end
      end
      ST_GUARD: begin
        if (bus.flush || !gap) begin
          state_d = ST_IDLE;
          guard_d = '0;
        end else if (guard_q == GUARD_LAST) begin
          guard_d = '0;
          state_d = (count_d == '0) ? ST_DONE : ST_WRITE;
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end
      ST_WRITE: begin
        if (bus.flush || !gap || count_d == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        guard_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        guard_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      guard_q      <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      host_ready_q <= 1'b1;
      wr_en_q      <= 1'b0;
      burst_done_q <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      guard_q      <= guard_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      host_ready_q <= (count_d != CW'(DEPTH));
      burst_done_q <= (state_q == ST_DONE);
      wr_en_q      <= pop;
      if (pop) {addr_q, data_q} <= mem[rd_ptr_q];
      if (bus.flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_q] <= {bus.host_addr, bus.host_data};
  end

  assign bus.host_ready = host_ready_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.varAddress = addr_q;
  assign bus.varValueIn = data_q;
  assign bus.pending    = count_q;
  assign bus.burst_done = burst_done_q;
  assign bus.overflow   = overflow_q;
endmodule
